inj_vc_buffer: RTL

- Injection-side buffer directly downstream of the traffic generator.
- Accepts flits tagged with a VC and stores them in per-VC FIFOs.
- Forwards them one flit per cycle onto the router's local input link under credit-based flow control.
- Arbitrates between VCs at packet granularity: once a head flit is granted, that VC owns the link until its tail flit.

---
 rtl/inj_vc_buffer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/inj_vc_buffer.sv
// rtl/inj_vc_buffer.sv - per-VC injection FIFOs with packet-granular RR arbitration and credit flow control
module inj_vc_buffer #(
    parameter int FLIT_W  = 16,
    parameter int NUM_VC  = 2,
    parameter int VC_W    = 1,
    parameter int DEPTH   = 4,
    parameter int CREDITS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [FLIT_W-1:0] in_flit,
    input  logic [VC_W-1:0]   in_vc,
    output logic [NUM_VC-1:0] in_ready,
    output logic              out_valid,
    output logic [FLIT_W-1:0] out_flit,
    output logic [VC_W-1:0]   out_vc,
    input  logic [NUM_VC-1:0] credit_in,
    output logic              err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CREDITS + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    logic [FLIT_W-1:0] mem_q    [NUM_VC][DEPTH];
    logic [AW:0]       wr_ptr_q [NUM_VC];
    logic [AW:0]       rd_ptr_q [NUM_VC];
    logic [CW-1:0]     cred_q   [NUM_VC];
    state_t            state_q;
    logic [VC_W-1:0]   lock_vc_q;
    logic [VC_W-1:0]   rr_q;
    logic              err_q;

    logic [FLIT_W-1:0] front [NUM_VC];
    logic [NUM_VC-1:0] elig;
    logic [NUM_VC-1:0] send;
    logic [NUM_VC-1:0] drop;
    logic              found;
    logic [VC_W-1:0]   grant_vc;
    logic [VC_W-1:0]   idx;
    logic              lock_head_err;

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            front[v]    = mem_q[v][rd_ptr_q[v][AW-1:0]];
            elig[v]     = (wr_ptr_q[v] != rd_ptr_q[v]) && (cred_q[v] != '0);
            in_ready[v] = !((wr_ptr_q[v][AW] != rd_ptr_q[v][AW]) &&
                            (wr_ptr_q[v][AW-1:0] == rd_ptr_q[v][AW-1:0]));
        end
    end

    // In IDLE every eligible VC fronted by a non-head flit is flushed, independent of the grant.
    always_comb begin
        send          = '0;
        drop          = '0;
        found         = 1'b0;
        grant_vc      = '0;
        idx           = '0;
        lock_head_err = 1'b0;
        if (state_q == IDLE) begin
            for (int i = 1; i <= NUM_VC; i++) begin
                idx = rr_q + VC_W'(i);
                if (elig[idx]) begin
                    if (front[idx][FLIT_W-1]) begin
                        if (!found) begin
                            found    = 1'b1;
                            grant_vc = idx;
                        end
                    end else begin
                        drop[idx] = 1'b1;
                    end
                end
            end
        end else if (elig[lock_vc_q]) begin
            found         = 1'b1;
            grant_vc      = lock_vc_q;
            lock_head_err = front[lock_vc_q][FLIT_W-1];
        end
        if (found) begin
            send[grant_vc] = 1'b1;
        end
    end

    assign out_valid = found && rst_n;
    assign out_flit  = front[grant_vc];
    assign out_vc    = grant_vc;
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                cred_q[v]   <= CW'(CREDITS);
            end
            state_q   <= IDLE;
            lock_vc_q <= '0;
            rr_q      <= VC_W'(NUM_VC - 1);
            err_q     <= 1'b0;
        end else begin
            if (in_valid) begin
                if (in_ready[in_vc]) begin
                    mem_q[in_vc][wr_ptr_q[in_vc][AW-1:0]] <= in_flit;
                    wr_ptr_q[in_vc] <= wr_ptr_q[in_vc] + (AW+1)'(1);
                end else begin
                    err_q <= 1'b1;
                end
            end
            for (int v = 0; v < NUM_VC; v++) begin
                if (send[v] || drop[v]) begin
                    rd_ptr_q[v] <= rd_ptr_q[v] + (AW+1)'(1);
                end
                case ({send[v], credit_in[v]})
                    2'b10:   cred_q[v] <= cred_q[v] - CW'(1);
                    2'b01: begin
                        if (cred_q[v] == CW'(CREDITS)) begin
                            err_q <= 1'b1;
                        end else begin
                            cred_q[v] <= cred_q[v] + CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
            if ((|drop) || lock_head_err) begin
                err_q <= 1'b1;
            end
            if (found) begin
                if (state_q == IDLE) begin
                    rr_q <= grant_vc;
                    if (!out_flit[FLIT_W-2]) begin
                        state_q   <= LOCKED;
                        lock_vc_q <= grant_vc;
                    end
                end else if (out_flit[FLIT_W-2]) begin
                    state_q <= IDLE;
                end
            end
        end
    end
endmodule
